// File: rtl/trace_checker_if.sv
// trace_checker_if
//   Bundles the CPU writeback debug trace that the checker consumes.
//   master : the CPU (or bench) driving the trace
//   slave  : the trace_checker observing it
// Signals:
//   debug_wb_have_inst  trace valid for this cycle
//   debug_wb_pc   [31:0] PC of the retiring instruction
//   debug_wb_ena        register-write enable
//   debug_wb_reg  [4:0] destination register
//   debug_wb_value[31:0] value written
interface trace_checker_if;
  logic        debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;

  modport master (
    output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value
  );

  modport slave (
    input debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value
  );
endinterface

// File: rtl/trace_checker.sv
// trace_checker
//   Compares the CPU writeback trace, in order, against a golden list of
//   expected register writes and reports pass, fail (mismatch details latched)
//   or timeout.
//
// Optional feature macro: TRACE_CHECK_PC_EN
//   defined     : the trace PC must also equal the golden PC
//   not defined : golden PC is stored but ignored in compares
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   gold_we/addr/data  golden write port (IDLE only), data = {pc, reg, value}
//   exp_cnt            entries to check, sampled on start
//   start, clear       IDLE->RUN pulse, any->IDLE pulse (clear wins)
//   wb                 writeback trace (trace_checker_if.slave)
//   busy, done, pass   RUN, PASS|FAIL, PASS
//   timeout            FAIL caused by inactivity
//   match_cnt          entries matched so far
//   err_pc/exp/act/reg details of the first mismatch
//
// state  | meaning
// S_IDLE | golden load allowed, waiting for start
// S_RUN  | comparing qualifying trace events against gold[idx]
// S_PASS | all cnt entries matched (terminal until clear)
// S_FAIL | mismatch or timeout (terminal until clear)
module trace_checker #(
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 4096,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gold_we,
  input  logic [AW-1:0] gold_addr,
  input  logic [68:0]   gold_data,
  input  logic [CW-1:0] exp_cnt,
  input  logic          start,
  input  logic          clear,
  trace_checker_if.slave wb,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [CW-1:0] match_cnt,
  output logic [31:0]   err_pc,
  output logic [31:0]   err_exp,
  output logic [31:0]   err_act,
  output logic [4:0]    err_reg
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t        state;
  logic [68:0]   gold [DEPTH];
  logic [CW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo_cnt;
  logic [68:0]   gold_entry;
  logic          qual;
  logic          pc_diff;
  logic          mismatch;
  logic          last_match;

  // Golden memory has no reset; contents survive rst_n and clear.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && gold_we && !clear)
      gold[gold_addr] <= gold_data;
  end

  assign gold_entry = gold[idx[AW-1:0]];
  assign qual       = wb.debug_wb_have_inst & wb.debug_wb_ena & (wb.debug_wb_reg != 5'd0);

`ifdef TRACE_CHECK_PC_EN
  assign pc_diff = (wb.debug_wb_pc != gold_entry[68:37]);
`else
  logic unused_gold_pc;
  assign unused_gold_pc = ^gold_entry[68:37];
  assign pc_diff        = 1'b0;
`endif

  assign mismatch   = pc_diff
                    | (wb.debug_wb_reg   != gold_entry[36:32])
                    | (wb.debug_wb_value != gold_entry[31:0]);
  // idx < cnt <= DEPTH while in RUN, so idx + 1 cannot overflow CW bits.
  assign last_match = ((idx + CW'(1)) == cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      match_cnt <= '0;
      err_pc    <= '0;
      err_exp   <= '0;
      err_act   <= '0;
      err_reg   <= '0;
    end else if (clear) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      match_cnt <= '0;
      err_pc    <= '0;
      err_exp   <= '0;
      err_act   <= '0;
      err_reg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            tmo_cnt   <= '0;
            match_cnt <= '0;
            timeout   <= 1'b0;
            err_pc    <= '0;
            err_exp   <= '0;
            err_act   <= '0;
            err_reg   <= '0;
            cnt       <= (exp_cnt > DEPTH_C) ? DEPTH_C : exp_cnt;
            if (exp_cnt == '0) begin
              state <= S_PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (qual) begin
            if (mismatch) begin
              err_pc  <= wb.debug_wb_pc;
              err_reg <= wb.debug_wb_reg;
              err_act <= wb.debug_wb_value;
              err_exp <= gold_entry[31:0];
              state   <= S_FAIL;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx       <= idx + CW'(1);
              match_cnt <= match_cnt + CW'(1);
              tmo_cnt   <= '0;
              if (last_match) begin
                state <= S_PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= S_FAIL;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_checker.sv
module tb_trace_checker;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          gold_we;
  logic [AW-1:0] gold_addr;
  logic [68:0]   gold_data;
  logic [CW-1:0] exp_cnt;
  logic          start;
  logic          clear;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] match_cnt;
  logic [31:0]   err_pc, err_exp, err_act;
  logic [4:0]    err_reg;

  trace_checker_if wb ();

  trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gold_we   (gold_we),
    .gold_addr (gold_addr),
    .gold_data (gold_data),
    .exp_cnt   (exp_cnt),
    .start     (start),
    .clear     (clear),
    .wb        (wb.slave),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .match_cnt (match_cnt),
    .err_pc    (err_pc),
    .err_exp   (err_exp),
    .err_act   (err_act),
    .err_reg   (err_reg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          st;
    logic          clr;
    logic          have;
    logic          ena;
    logic [4:0]    rg;
    logic [31:0]   pc;
    logic [31:0]   val;
    logic          e_busy;
    logic          e_done;
    logic          e_pass;
    logic [CW-1:0] e_match;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic have, input logic ena, input logic [4:0] rg,
                          input logic [31:0] pc, input logic [31:0] val);
    wb.debug_wb_have_inst = have;
    wb.debug_wb_ena       = ena;
    wb.debug_wb_reg       = rg;
    wb.debug_wb_pc        = pc;
    wb.debug_wb_value     = val;
  endtask

  task automatic idle_ev();
    drive_ev(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic load(input int addr, input logic [31:0] pc, input logic [4:0] rg,
                      input logic [31:0] val);
    gold_we   = 1'b1;
    gold_addr = AW'(addr);
    gold_data = {pc, rg, val};
    tick();
    gold_we   = 1'b0;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    exp_cnt = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},    32'(busy),      32'd0);
    chk({tag, " done"},    32'(done),      32'd0);
    chk({tag, " pass"},    32'(pass),      32'd0);
    chk({tag, " timeout"}, 32'(timeout),   32'd0);
    chk({tag, " match"},   32'(match_cnt), 32'd0);
    chk({tag, " err_pc"},  err_pc,         32'd0);
    chk({tag, " err_exp"}, err_exp,        32'd0);
    chk({tag, " err_act"}, err_act,        32'd0);
    chk({tag, " err_reg"}, 32'(err_reg),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    gold_we = 1'b0; gold_addr = '0; gold_data = '0;
    exp_cnt = '0; start = 1'b0; clear = 1'b0;
    idle_ev();

    // start, clr, have, ena, reg, pc, value -> busy, done, pass, match
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0, 32'd5,     1'b1, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0, 32'd5,     1'b1, 1'b0, 1'b0, 4'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h4, 32'hDEAD,  1'b1, 1'b0, 1'b0, 4'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h4, 32'hDEAD,  1'b1, 1'b0, 1'b0, 4'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h4, 32'd7,     1'b1, 1'b0, 1'b0, 4'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h4, 32'd7,     1'b1, 1'b0, 1'b0, 4'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hC, 32'd12,    1'b0, 1'b1, 1'b1, 4'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0, 32'd99,    1'b0, 1'b1, 1'b1, 4'd3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd0,     1'b0, 1'b1, 1'b1, 4'd3};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'd0,     1'b0, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd0,     1'b1, 1'b0, 1'b0, 4'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0, 32'd5,     1'b1, 1'b0, 1'b0, 4'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h4, 32'd7,     1'b1, 1'b0, 1'b0, 4'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hC, 32'd12,    1'b0, 1'b1, 1'b1, 4'd3};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'd0,     1'b0, 1'b0, 1'b0, 4'd0};

    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    load(0, 32'h0, 5'd1, 32'd5);
    load(1, 32'h4, 5'd2, 32'd7);
    load(2, 32'hC, 5'd3, 32'd12);

    // Clean run with skipped events, terminal-state and clear/start priority.
    exp_cnt = 4'd3;
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].st;
      clear = vecs[i].clr;
      drive_ev(vecs[i].have, vecs[i].ena, vecs[i].rg, vecs[i].pc, vecs[i].val);
      tick();
      chk($sformatf("vec%0d busy", i),    32'(busy),      32'(vecs[i].e_busy));
      chk($sformatf("vec%0d done", i),    32'(done),      32'(vecs[i].e_done));
      chk($sformatf("vec%0d pass", i),    32'(pass),      32'(vecs[i].e_pass));
      chk($sformatf("vec%0d match", i),   32'(match_cnt), 32'(vecs[i].e_match));
      chk($sformatf("vec%0d timeout", i), 32'(timeout),   32'd0);
    end
    start = 1'b0; clear = 1'b0; idle_ev();

    // Value mismatch; a golden write during RUN must not take effect.
    pulse_start(4'd3);
    chk("mm busy", 32'(busy), 32'd1);
    drive_ev(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
    tick();
    drive_ev(1'b1, 1'b1, 5'd2, 32'h4, 32'd8);
    gold_we = 1'b1; gold_addr = AW'(1); gold_data = {32'h4, 5'd2, 32'd8};
    tick();
    gold_we = 1'b0;
    chk("mm busy0",   32'(busy),      32'd0);
    chk("mm done",    32'(done),      32'd1);
    chk("mm pass",    32'(pass),      32'd0);
    chk("mm timeout", 32'(timeout),   32'd0);
    chk("mm match",   32'(match_cnt), 32'd1);
    chk("mm err_exp", err_exp,        32'd7);
    chk("mm err_act", err_act,        32'd8);
    chk("mm err_reg", 32'(err_reg),   32'd2);
    chk("mm err_pc",  err_pc,         32'h4);
    drive_ev(1'b1, 1'b1, 5'd3, 32'hC, 32'd99);
    tick();
    idle_ev();
    chk("mm hold act",   err_act,        32'd8);
    chk("mm hold match", 32'(match_cnt), 32'd1);
    pulse_clear();
    chk_all_zero("mm clear");

    // Timeout, with a match in the middle restarting the count.
    pulse_start(4'd3);
    repeat (10) tick();
    drive_ev(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
    tick();
    idle_ev();
    repeat (15) tick();
    chk("tmo not yet busy", 32'(busy), 32'd1);
    chk("tmo not yet done", 32'(done), 32'd0);
    tick();
    chk("tmo done",    32'(done),      32'd1);
    chk("tmo flag",    32'(timeout),   32'd1);
    chk("tmo pass",    32'(pass),      32'd0);
    chk("tmo busy",    32'(busy),      32'd0);
    chk("tmo match",   32'(match_cnt), 32'd1);
    chk("tmo err_act", err_act,        32'd0);
    chk("tmo err_pc",  err_pc,         32'd0);
    pulse_clear();
    chk_all_zero("tmo clear");

    // PC difference only.
    pulse_start(4'd2);
    drive_ev(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
    tick();
    drive_ev(1'b1, 1'b1, 5'd2, 32'h8, 32'd7);
    tick();
    idle_ev();
`ifdef TRACE_CHECK_PC_EN
    chk("pc done",    32'(done),      32'd1);
    chk("pc pass",    32'(pass),      32'd0);
    chk("pc match",   32'(match_cnt), 32'd1);
    chk("pc err_pc",  err_pc,         32'h8);
    chk("pc err_exp", err_exp,        32'd7);
    chk("pc err_act", err_act,        32'd7);
`else
    chk("pc done",  32'(done),      32'd1);
    chk("pc pass",  32'(pass),      32'd1);
    chk("pc match", 32'(match_cnt), 32'd2);
`endif
    pulse_clear();

    // exp_cnt above DEPTH clamps to DEPTH.
    for (int i = 0; i < DEPTH; i++)
      load(i, 32'(4 * i), 5'(i + 1), 32'(3 * i + 1));
    pulse_start(4'd12);
    for (int i = 0; i < DEPTH; i++) begin
      drive_ev(1'b1, 1'b1, 5'(i + 1), 32'(4 * i), 32'(3 * i + 1));
      tick();
      if (i == DEPTH - 2) begin
        chk("clamp busy7",  32'(busy),      32'd1);
        chk("clamp match7", 32'(match_cnt), 32'd7);
      end
    end
    idle_ev();
    chk("clamp pass",  32'(pass),      32'd1);
    chk("clamp match", 32'(match_cnt), 32'd8);
    pulse_clear();

    // Asynchronous reset mid-RUN, then an empty start.
    pulse_start(4'd3);
    drive_ev(1'b1, 1'b1, 5'd1, 32'h0, 32'd1);
    tick();
    idle_ev();
    chk("arst pre match", 32'(match_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy",  32'(busy),      32'd0);
    chk("arst match", 32'(match_cnt), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    pulse_start(4'd0);
    chk("empty pass", 32'(pass), 32'd1);
    chk("empty done", 32'(done), 32'd1);
    chk("empty busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
